// File: rtl/jtag_config_pkg.sv
// Shared constants and state encoding for the JTAG configuration bit-stream
// transmitter (and a future receiver rewrite).
package jtag_config_pkg;

    localparam int WORD_W  = 32;
    localparam int TAG_W   = 16;
    localparam int FRAME_W = WORD_W + TAG_W;
    localparam int CNT_W   = 6;

    localparam logic [TAG_W-1:0] SYNC_WORD = 16'hFAB2;
    localparam logic [TAG_W-1:0] END_WORD  = 16'hFAB3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_FRAME,
        ST_END,
        ST_TAIL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/jtag_shift_out.sv
// Loadable MSB-first shift register with bit counter; o_last flags the cycle
// in which bit i_stop_at is being shifted out.
module jtag_shift_out #(
    parameter int DATA_W = 48,
    parameter int CNT_W  = 6
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_load_data,
    input  logic              i_shift,
    input  logic [CNT_W-1:0]  i_stop_at,
    output logic              o_msb,
    output logic              o_last
);

    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_cnt;

    // Load wins over shift so a back-to-back frame replaces the outgoing one.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shreg <= '0;
            r_cnt   <= '0;
        end else if (i_load) begin
            r_shreg <= i_load_data;
            r_cnt   <= '0;
        end else if (i_shift) begin
            r_shreg <= {r_shreg[DATA_W-2:0], 1'b0};
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    assign o_msb  = r_shreg[DATA_W-1];
    assign o_last = (r_cnt == i_stop_at);

endmodule

// File: rtl/jtag_config_tx.sv
// Serializes 32-bit configuration words as {word, FAB2} frames, terminated by
// FAB3 and a few idle zero bits, for the JTAG configuration receiver.
module jtag_config_tx
    import jtag_config_pkg::*;
#(
    parameter int TAIL_BITS = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] word_data,
    input  logic              word_last,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              done,
    output logic              underrun
);

    localparam int TCNT_W = $clog2(TAIL_BITS + 1);

    state_t              r_state;
    logic                r_last_q;
    logic                r_serial;
    logic                r_underrun;
    logic [TCNT_W-1:0]   r_tcnt;

    logic                w_msb;
    logic                w_last;
    logic                w_boundary;
    logic                w_xfer;
    logic                w_load;
    logic                w_shift;
    logic [FRAME_W-1:0]  w_load_data;
    logic [CNT_W-1:0]    w_stop_at;

    assign w_boundary = (r_state == ST_FRAME) && w_last;
    assign word_ready = (r_state == ST_ARMED) || (w_boundary && !r_last_q);
    assign w_xfer     = word_valid && word_ready;

    // Every frame boundary reloads: either the next word or the end word.
    assign w_load      = w_xfer || w_boundary;
    assign w_load_data = w_xfer ? {word_data, SYNC_WORD} : {END_WORD, {WORD_W{1'b0}}};
    assign w_shift     = (r_state == ST_FRAME) || (r_state == ST_END);
    assign w_stop_at   = (r_state == ST_END) ? CNT_W'(TAG_W - 1) : CNT_W'(FRAME_W - 1);

    jtag_shift_out #(
        .DATA_W (FRAME_W),
        .CNT_W  (CNT_W)
    ) u_shift (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_load      (w_load),
        .i_load_data (w_load_data),
        .i_shift     (w_shift),
        .i_stop_at   (w_stop_at),
        .o_msb       (w_msb),
        .o_last      (w_last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_last_q   <= 1'b0;
            r_serial   <= 1'b0;
            r_underrun <= 1'b0;
            r_tcnt     <= '0;
        end else begin
            r_serial <= w_shift ? w_msb : 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_ARMED;
                        r_underrun <= 1'b0;
                    end
                end
                ST_ARMED: begin
                    if (w_xfer) begin
                        r_last_q <= word_last;
                        r_state  <= ST_FRAME;
                    end
                end
                ST_FRAME: begin
                    if (w_last) begin
                        if (w_xfer) begin
                            r_last_q <= word_last;
                        end else begin
                            r_underrun <= r_underrun | !r_last_q;
                            r_state    <= ST_END;
                        end
                    end
                end
                ST_END: begin
                    if (w_last) begin
                        r_state <= ST_TAIL;
                        r_tcnt  <= '0;
                    end
                end
                // The extra count lets the last tail zero reach the line before done.
                ST_TAIL: begin
                    if (r_tcnt == TCNT_W'(TAIL_BITS)) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign serial_out = r_serial;
    assign underrun   = r_underrun;
    assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done       = (r_state == ST_DONE);

endmodule

// File: tb/tb_jtag_config_tx.sv
// Self-checking bench for jtag_config_tx: directed vector table, hand-written
// corner sequences and randomized streams checked against a line-level model.
module tb_jtag_config_tx;

    localparam int LOGN  = 8192;
    localparam int TAILN = 2;

    logic        clk = 1'b0;
    logic        reset, start, word_valid, word_last;
    logic [31:0] word_data;
    logic        word_ready, serial_out, busy, done, underrun;

    jtag_config_tx #(.TAIL_BITS(TAILN)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_data  (word_data),
        .word_last  (word_last),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    bit log_ser[LOGN], log_rdy[LOGN], log_busy[LOGN];
    bit log_done[LOGN], log_under[LOGN], log_xfer[LOGN];

    always @(posedge clk) begin
        if (cyc < LOGN) log_xfer[cyc] = word_valid && word_ready;
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (cyc < LOGN) begin
            log_ser[cyc]   = serial_out;
            log_rdy[cyc]   = word_ready;
            log_busy[cyc]  = busy;
            log_done[cyc]  = done;
            log_under[cyc] = underrun;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    logic [31:0] s_words[8];
    int          s_n, s_gap, s_poke, cx_g;
    bit          exp_bits[512];

    // Reference line image: frames {word, FAB2}, then FAB3, then tail zeros.
    function automatic int build_expected(input int nf);
        logic [15:0] sw;
        logic [15:0] ew;
        int          len;
        sw  = 16'hFAB2;
        ew  = 16'hFAB3;
        len = 0;
        for (int f = 0; f < nf; f++) begin
            for (int b = 31; b >= 0; b--) begin exp_bits[len] = s_words[f][b]; len++; end
            for (int b = 15; b >= 0; b--) begin exp_bits[len] = sw[b]; len++; end
        end
        for (int b = 15; b >= 0; b--) begin exp_bits[len] = ew[b]; len++; end
        for (int b = 0; b < TAILN; b++) begin exp_bits[len] = 1'b0; len++; end
        return len;
    endfunction

    function automatic int count_exp_tag(input int len, input logic [15:0] tag);
        logic [15:0] win;
        int          n;
        win = '0;
        n   = 0;
        for (int k = 0; k < len; k++) begin
            win = {win[14:0], exp_bits[k]};
            if (k >= 15 && win == tag) n++;
        end
        return n;
    endfunction

    task automatic tick();
        @(negedge clk);
        start = (s_poke >= 0 && cx_g >= 0 && cyc == cx_g + 1 + s_poke);
    endtask

    // Plays one stream; cx is the sample index of the first accepted word.
    task automatic run_stream(output int cx);
        int budget;
        cx_g  = -1;
        start = 1'b1;
        tick();
        for (int i = 0; i < s_n; i++) begin
            if (i == s_gap) break;
            word_data  = s_words[i];
            word_last  = (i == s_n - 1);
            word_valid = 1'b1;
            budget = 0;
            while (!word_ready && budget < 200) begin tick(); budget++; end
            if (!word_ready) begin
                chk("ready_timeout", 64'd0, 64'd1);
                break;
            end
            if (cx_g < 0) cx_g = cyc;
            tick();
        end
        word_valid = 1'b0;
        word_last  = 1'b0;
        word_data  = $urandom;
        budget = 0;
        while (!done && budget < 400) begin tick(); budget++; end
        chk("done_reached", done, 1);
        tick();
        tick();
        cx = cx_g;
    endtask

    task automatic check_stream(input string nm, input int cx, input int nf, input bit exp_under);
        int          len, nbad, e3, werr, d, fi;
        int          ends[$];
        logic [15:0] win;
        logic [31:0] wd;
        bit          ex, er;
        if (cx < 0 || cx + 48 * nf + 40 >= LOGN) begin
            chk({nm, "_anchor"}, 64'd0, 64'd1);
            return;
        end
        len  = build_expected(nf);
        nbad = 0;
        for (int j = 0; j <= len + 1; j++) begin
            ex = (j >= 1 && j <= len) ? exp_bits[j-1] : 1'b0;
            if (log_ser[cx+1+j] != ex) nbad++;
        end
        chk({nm, "_line_bit_errors"}, nbad, 0);
        chk({nm, "_done_edge"}, {log_done[cx+1+len], log_done[cx+2+len]}, 2'b01);
        chk({nm, "_underrun"}, log_under[cx+2+len], exp_under);
        nbad = 0;
        for (int c = cx; c <= cx + 2 + len; c++)
            if (log_busy[c] != (c <= cx + 1 + len)) nbad++;
        chk({nm, "_busy_errors"}, nbad, 0);
        nbad = 0;
        for (int c = cx; c <= cx + 2 + len; c++) begin
            d  = c - cx;
            fi = d / 48 - 1;
            ex = (d % 48 == 0) && (d / 48 < nf);
            er = (d == 0) || ((d % 48 == 0) && fi >= 0 && fi < nf && fi != s_n - 1);
            if (log_xfer[c] != ex) nbad++;
            if (log_rdy[c] != er) nbad++;
        end
        chk({nm, "_handshake_errors"}, nbad, 0);
        // Receiver's view: find sync tags on the line and pull out the words.
        win  = '0;
        e3   = -1;
        werr = 0;
        for (int k = 0; k < len; k++) begin
            win = {win[14:0], log_ser[cx+2+k]};
            if (k >= 15 && win == 16'hFAB2) ends.push_back(k);
            if (k >= 15 && win == 16'hFAB3 && e3 < 0) e3 = k;
        end
        chk({nm, "_rx_frames"}, ends.size(), nf);
        for (int f = 0; f < ends.size(); f++) begin
            if (ends[f] < 47 || f >= nf) begin
                werr++;
            end else begin
                for (int b = 0; b < 32; b++) wd[31-b] = log_ser[cx+2+ends[f]-47+b];
                if (wd != s_words[f]) werr++;
            end
            if (f > 0 && ends[f] - ends[f-1] != 48) werr++;
        end
        if (ends.size() == 0 || e3 != ends[ends.size()-1] + 16) werr++;
        chk({nm, "_rx_word_errors"}, werr, 0);
    endtask

    typedef struct {
        string       name;
        logic [31:0] w0, w1, w2;
        int          n, gap, poke, exp_frames;
        bit          exp_under;
    } vec_t;

    vec_t vecs[5];

    task automatic set_vec(input int idx, input string nm, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] c, input int n,
                           input int gap, input int poke, input int frames, input bit und);
        vecs[idx].name = nm;  vecs[idx].w0 = a;  vecs[idx].w1 = b;  vecs[idx].w2 = c;
        vecs[idx].n = n;  vecs[idx].gap = gap;  vecs[idx].poke = poke;
        vecs[idx].exp_frames = frames;  vecs[idx].exp_under = und;
    endtask

    initial begin
        int cx, nf, len, tries;
        set_vec(0, "single",       32'h12345678, 32'h0,        32'h0,        1, -1, -1, 1, 1'b0);
        set_vec(1, "back_to_back", 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h00000001, 3, -1, -1, 3, 1'b0);
        set_vec(2, "underrun",     32'h12345678, 32'h11111111, 32'h0,        2,  1, -1, 1, 1'b1);
        set_vec(3, "start_busy",   32'h3C3C3C3C, 32'h0,        32'h0,        1, -1, 10, 1, 1'b0);
        set_vec(4, "two_words",    32'h11223344, 32'h55667788, 32'h0,        2, -1, -1, 2, 1'b0);

        reset = 1'b1;  start = 1'b0;  word_valid = 1'b0;  word_last = 1'b0;  word_data = '0;
        s_poke = -1;  s_gap = -1;  s_n = 0;  cx_g = -1;
        repeat (3) @(negedge clk);
        chk("rst_serial_out", serial_out, 0);
        chk("rst_busy",       busy,       0);
        chk("rst_done",       done,       0);
        chk("rst_underrun",   underrun,   0);
        chk("rst_word_ready", word_ready, 0);
        reset = 1'b0;
        tick();

        for (int v = 0; v < 5; v++) begin
            s_words[0] = vecs[v].w0;  s_words[1] = vecs[v].w1;  s_words[2] = vecs[v].w2;
            s_n = vecs[v].n;  s_gap = vecs[v].gap;  s_poke = vecs[v].poke;
            run_stream(cx);
            check_stream(vecs[v].name, cx, vecs[v].exp_frames, vecs[v].exp_under);
            s_poke = -1;
            if (v == 2) begin
                repeat (5) tick();
                chk("underrun_sticky", underrun, 1);
                chk("underrun_done_held", done, 1);
                start = 1'b1;
                tick();
                chk("underrun_cleared_by_start", underrun, 0);
                chk("done_cleared_by_start", done, 0);
                chk("rearmed_ready", word_ready, 1);
            end
        end

        // Reset in the middle of a frame, while a 1 is on the line.
        s_words[0] = 32'h12345678;  s_n = 1;  s_gap = -1;  s_poke = -1;  cx_g = -1;
        start = 1'b1;
        tick();
        word_data = s_words[0];  word_last = 1'b1;  word_valid = 1'b1;
        chk("mid_armed_ready", word_ready, 1);
        cx_g = cyc;
        tick();
        word_valid = 1'b0;
        while (cyc < cx_g + 2 + 21) tick();
        chk("mid_bit21", serial_out, 1);
        chk("mid_busy", busy, 1);
        reset = 1'b1;
        tick();
        chk("mid_rst_serial_out", serial_out, 0);
        chk("mid_rst_busy",       busy,       0);
        chk("mid_rst_word_ready", word_ready, 0);
        chk("mid_rst_done",       done,       0);
        reset = 1'b0;
        tick();

        for (int r = 0; r < 12; r++) begin
            s_n    = $urandom_range(1, 3);
            s_gap  = (s_n > 1 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, s_n - 1)) : -1;
            s_poke = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 47)) : -1;
            nf     = (s_gap < 0) ? s_n : s_gap;
            tries  = 0;
            do begin
                for (int i = 0; i < s_n; i++) s_words[i] = $urandom;
                len = build_expected(nf);
                tries++;
            end while ((count_exp_tag(len, 16'hFAB2) != nf || count_exp_tag(len, 16'hFAB3) != 1)
                       && tries < 100);
            run_stream(cx);
            check_stream("random", cx, nf, s_gap >= 0);
            s_poke = -1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by 1000000 time units, expected completion");
        $fatal(1);
    end

endmodule
